fifo_rd_stream: RTL

Read-side adapter for the asynchronous FIFO. It sits in the `rclk` domain and pops words through the FIFO read port (`rinc`/`rdata`/`rempty`). It presents those words to downstream logic as a valid/ready stream, using a 2-entry skid buffer for full throughput under backpressure. It is the consumer counterpart of the write-side producer that drives `winc`/`wdata` against `wfull`.

---
 rtl/fifo_rd_stream.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter for the asynchronous FIFO (rclk domain).
// Pops show-ahead FIFO words and presents them as a valid/ready stream
// through a 2-entry skid buffer (head + skid) so throughput stays at one
// word per cycle under backpressure.
// Optional feature macro: FIFO_RD_CNT_EN adds the rd_count popped-word counter.
//
// state  | meaning
// -------+---------------------------------------------------
// OCC_0  | buffer empty, m_valid low
// OCC_1  | one word buffered in head
// OCC_2  | two words buffered: head (older) and skid (newer)

module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             en,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0] rd_count
`endif
);

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_e;

  occ_e             occ;
  occ_e             occ_nxt;
  logic [DSIZE-1:0] head;
  logic [DSIZE-1:0] skid;
  logic             push;
  logic             pop;
  logic             head_ld_rdata;
  logic             head_ld_skid;
  logic             skid_ld_rdata;

  // Occupancy state register; reset discards anything buffered.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ <= OCC_0;
    end else begin
      occ <= occ_nxt;
    end
  end

  // Pop decision, next occupancy and which buffer registers load this cycle.
  // rrst_n is folded into the pop strobe so the FIFO is never popped while
  // this side is held in reset.
  always_comb begin
    occ_nxt       = occ;
    head_ld_rdata = 1'b0;
    head_ld_skid  = 1'b0;
    skid_ld_rdata = 1'b0;
    push = rrst_n & en & ~rempty & ((occ != OCC_2) | m_ready);
    pop  = (occ != OCC_0) & m_ready;
    case (occ)
      OCC_0: begin
        if (push) begin
          occ_nxt       = OCC_1;
          head_ld_rdata = 1'b1;
        end
      end
      OCC_1: begin
        if (push && pop) begin
          head_ld_rdata = 1'b1;
        end else if (push) begin
          occ_nxt       = OCC_2;
          skid_ld_rdata = 1'b1;
        end else if (pop) begin
          occ_nxt = OCC_0;
        end
      end
      OCC_2: begin
        // In OCC_2 a push always coincides with a pop (push needs m_ready).
        if (pop) begin
          head_ld_skid = 1'b1;
          if (push) begin
            skid_ld_rdata = 1'b1;
          end else begin
            occ_nxt = OCC_1;
          end
        end
      end
      default: begin
        occ_nxt = OCC_0;
      end
    endcase
  end

  // Buffer data registers; head keeps its last word when the buffer empties.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (head_ld_rdata) begin
        head <= rdata;
      end else if (head_ld_skid) begin
        head <= skid;
      end
      if (skid_ld_rdata) begin
        skid <= rdata;
      end
    end
  end

  assign rinc    = push;
  assign m_valid = (occ != OCC_0);
  assign m_data  = head;

`ifdef FIFO_RD_CNT_EN
  // Free-running count of FIFO pops, wrapping at 2^CNT_W.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_count <= '0;
    end else if (push) begin
      rd_count <= rd_count + 1'b1;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
